// File: rtl/branch_predictor_bht_if.sv
// Pipeline-facing bundle for the BTB/BHT predictor: IF lookup, EX resolution,
// misprediction correction and statistics.
interface branch_predictor_bht_if #(
    parameter int STAT_W = 32
);
    logic [31:0]       pc_if;
    logic              pred_taken;
    logic [31:0]       pred_npc;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic              ex_taken;
    logic [31:0]       ex_target;
    logic              ex_pred_taken;
    logic [31:0]       ex_pred_npc;
    logic              mispredict;
    logic [31:0]       fix_npc;
    logic [STAT_W-1:0] branch_count;
    logic [STAT_W-1:0] miss_count;

    modport master (
        output pc_if, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_npc,
        input  pred_taken, pred_npc, mispredict, fix_npc, branch_count, miss_count
    );

    modport slave (
        input  pc_if, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_npc,
        output pred_taken, pred_npc, mispredict, fix_npc, branch_count, miss_count
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BTB with optional 2-bit saturating BHT per entry; combinational
// IF lookup, EX-stage update and misprediction detection, saturating statistics.
module branch_predictor_bht #(
    parameter int ENTRIES = 64,
    parameter int MODE    = 1,
    parameter int STAT_W  = 32
) (
    input logic                  clk,
    input logic                  rst,
    branch_predictor_bht_if.slave bus
);
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_W   = 30 - IDX_W;
    localparam bit USE_BHT = (MODE != 0);

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Valid and counter bits need reset, so they live in flops; tag/target do not.
    logic [ENTRIES-1:0]      valid_vec;
    logic [ENTRIES-1:0][1:0] ctr_vec;
    logic [TAG_W-1:0]        tag_mem    [ENTRIES];
    logic [31:0]             target_mem [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic             pred_taken_w;

    assign if_idx       = bus.pc_if[IDX_W+1:2];
    assign if_tag       = bus.pc_if[31:IDX_W+2];
    assign if_hit       = valid_vec[if_idx] && (tag_mem[if_idx] == if_tag);
    assign pred_taken_w = if_hit && (!USE_BHT || ctr_vec[if_idx][1]);

    assign bus.pred_taken = pred_taken_w;
    assign bus.pred_npc   = pred_taken_w ? target_mem[if_idx] : bus.pc_if + 32'd4;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ex_ctr;
    logic             mispredict_w;
    logic             upd;
    logic             entry_we;
    logic             valid_new;
    logic [1:0]       ctr_new;

    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[31:IDX_W+2];
    assign ex_hit = valid_vec[ex_idx] && (tag_mem[ex_idx] == ex_tag);
    assign ex_ctr = ctr_vec[ex_idx];

    assign mispredict_w = bus.ex_valid &&
                          (bus.ex_taken ? (bus.ex_pred_npc != bus.ex_target) : bus.ex_pred_taken);
    assign bus.mispredict = mispredict_w;
    assign bus.fix_npc    = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;

    // A not-taken miss leaves the table alone; everything else touches the entry.
    assign upd      = bus.ex_valid && !rst;
    assign entry_we = upd && (ex_hit || bus.ex_taken);

    always_comb begin
        valid_new = 1'b1;
        ctr_new   = ex_ctr;
        if (!ex_hit) begin
            ctr_new = 2'b10;
        end else if (bus.ex_taken) begin
            ctr_new = sat_inc(ex_ctr);
        end else if (USE_BHT) begin
            ctr_new = sat_dec(ex_ctr);
        end else begin
            valid_new = 1'b0;
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic       valid_reg;
        logic [1:0] ctr_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                ctr_reg   <= 2'b00;
            end else if (entry_we && (ex_idx == IDX_W'(gi))) begin
                valid_reg <= valid_new;
                ctr_reg   <= ctr_new;
            end
        end

        assign valid_vec[gi] = valid_reg;
        assign ctr_vec[gi]   = ctr_reg;
    end

    // Rewriting the tag on a taken hit is harmless: it is the same tag.
    always_ff @(posedge clk) begin
        if (upd && bus.ex_taken) begin
            target_mem[ex_idx] <= bus.ex_target;
            tag_mem[ex_idx]    <= ex_tag;
        end
    end

    logic [STAT_W-1:0] branch_count_reg;
    logic [STAT_W-1:0] miss_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_reg <= '0;
            miss_count_reg   <= '0;
        end else if (bus.ex_valid) begin
            if (branch_count_reg != '1) begin
                branch_count_reg <= branch_count_reg + STAT_W'(1);
            end
            if (mispredict_w && (miss_count_reg != '1)) begin
                miss_count_reg <= miss_count_reg + STAT_W'(1);
            end
        end
    end

    assign bus.branch_count = branch_count_reg;
    assign bus.miss_count   = miss_count_reg;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Drives a BHT-mode predictor (64 entries, 32-bit stats) and a BTB-only one
// (16 entries, 4-bit stats) with identical stimulus against a behavioural model.
module tb_branch_predictor_bht;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] pc_if, ex_pc, ex_target, ex_pred_npc;
    logic        ex_valid, ex_taken, ex_pred_taken;

    branch_predictor_bht_if #(.STAT_W(32)) bus_a ();
    branch_predictor_bht_if #(.STAT_W(4))  bus_b ();

    assign bus_a.pc_if = pc_if;          assign bus_b.pc_if = pc_if;
    assign bus_a.ex_valid = ex_valid;    assign bus_b.ex_valid = ex_valid;
    assign bus_a.ex_pc = ex_pc;          assign bus_b.ex_pc = ex_pc;
    assign bus_a.ex_taken = ex_taken;    assign bus_b.ex_taken = ex_taken;
    assign bus_a.ex_target = ex_target;  assign bus_b.ex_target = ex_target;
    assign bus_a.ex_pred_taken = ex_pred_taken;
    assign bus_b.ex_pred_taken = ex_pred_taken;
    assign bus_a.ex_pred_npc = ex_pred_npc;
    assign bus_b.ex_pred_npc = ex_pred_npc;

    branch_predictor_bht #(.ENTRIES(64), .MODE(1), .STAT_W(32)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    branch_predictor_bht #(.ENTRIES(16), .MODE(0), .STAT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model: each slot remembers the full word address (pc>>2) of its owner,
    // so a hit is simply "same word address as the stored one".
    int          ent  [2] = '{64, 16};
    int          mode [2] = '{1, 0};
    longint      cmax [2] = '{64'hFFFF_FFFF, 15};
    bit          m_valid [2][64];
    int unsigned m_key   [2][64];
    logic [31:0] m_tgt   [2][64];
    int          m_ctr   [2][64];
    longint      m_br    [2];
    longint      m_miss  [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic model_taken(input int d, input logic [31:0] pc);
        int unsigned w;
        int i;
        w = pc >> 2;
        i = int'(w % ent[d]);
        return m_valid[d][i] && (m_key[d][i] == w) && (mode[d] == 0 || m_ctr[d][i] >= 2);
    endfunction

    function automatic logic [31:0] model_npc(input int d, input logic [31:0] pc);
        int i;
        i = int'((pc >> 2) % ent[d]);
        return model_taken(d, pc) ? m_tgt[d][i] : pc + 32'd4;
    endfunction

    function automatic logic model_misp();
        if (!ex_valid) return 1'b0;
        if (ex_taken) return ex_pred_npc != ex_target;
        return ex_pred_taken;
    endfunction

    task automatic cmp(input int d, input string n, input logic pt, input logic [31:0] pn,
                       input logic mp, input logic [31:0] fx,
                       input logic [63:0] bc, input logic [63:0] mc);
        chk({n, ".pred_taken"}, pt, model_taken(d, pc_if));
        chk({n, ".pred_npc"}, pn, model_npc(d, pc_if));
        chk({n, ".mispredict"}, mp, model_misp());
        if (ex_valid)
            chk({n, ".fix_npc"}, fx, ex_taken ? ex_target : ex_pc + 32'd4);
        chk({n, ".branch_count"}, bc, 64'(m_br[d]));
        chk({n, ".miss_count"}, mc, 64'(m_miss[d]));
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp(0, "A", bus_a.pred_taken, bus_a.pred_npc, bus_a.mispredict, bus_a.fix_npc,
                64'(bus_a.branch_count), 64'(bus_a.miss_count));
            cmp(1, "B", bus_b.pred_taken, bus_b.pred_npc, bus_b.mispredict, bus_b.fix_npc,
                64'(bus_b.branch_count), 64'(bus_b.miss_count));
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 64; i++) begin
                    m_valid[d][i] = 1'b0;
                    m_ctr[d][i]   = 0;
                end
                m_br[d] = 0;
                m_miss[d] = 0;
            end else if (ex_valid) begin
                int unsigned w;
                int i;
                bit hit;
                if (m_br[d] < cmax[d]) m_br[d]++;
                if (model_misp() && m_miss[d] < cmax[d]) m_miss[d]++;
                w = ex_pc >> 2;
                i = int'(w % ent[d]);
                hit = m_valid[d][i] && (m_key[d][i] == w);
                if (hit && ex_taken) begin
                    m_tgt[d][i] = ex_target;
                    if (m_ctr[d][i] < 3) m_ctr[d][i]++;
                end else if (hit) begin
                    if (mode[d] == 1) begin
                        if (m_ctr[d][i] > 0) m_ctr[d][i]--;
                    end else begin
                        m_valid[d][i] = 1'b0;
                    end
                end else if (ex_taken) begin
                    m_valid[d][i] = 1'b1;
                    m_key[d][i]   = w;
                    m_tgt[d][i]   = ex_target;
                    m_ctr[d][i]   = 2;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ppt, input logic [31:0] ppn);
        ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = ppt; ex_pred_npc = ppn;
        if (v) $display("txn ex_pc=%08h taken=%0b target=%08h pred=%0b/%08h pc_if=%08h",
                        pc, tk, tgt, ppt, ppn, pc_if);
    endtask

    function automatic logic [31:0] rand_pc();
        return ($urandom_range(0, 3) << 12) | ($urandom_range(0, 63) << 2);
    endfunction

    initial begin
        rst = 1'b1;
        pc_if = 32'h100;
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;

        @(negedge clk);
        chk("reset.pred_taken", bus_a.pred_taken, 1'b0);
        chk("reset.pred_npc", bus_a.pred_npc, 32'h104);
        chk("reset.branch_count", 64'(bus_a.branch_count), 0);
        chk("reset.miss_count", 64'(bus_a.miss_count), 0);
        tick();

        // Allocate 0x100 -> 0x40 while looking it up in the same cycle
        set_ex(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        @(negedge clk);
        chk("alloc.mispredict", bus_a.mispredict, 1'b1);
        chk("alloc.fix_npc", bus_a.fix_npc, 32'h40);
        chk("alloc.same_cycle_taken", bus_a.pred_taken, 1'b0);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("hit.pred_taken", bus_a.pred_taken, 1'b1);
        chk("hit.pred_npc", bus_a.pred_npc, 32'h40);
        chk("hit.miss_count", 64'(bus_a.miss_count), 1);
        chk("hit.btb_only_taken", bus_b.pred_taken, 1'b1);
        tick();

        // Not-taken: BHT drops to weakly not-taken, BTB-only evicts
        set_ex(1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
        @(negedge clk);
        chk("nt.mispredict", bus_b.mispredict, 1'b1);
        chk("nt.fix_npc", bus_b.fix_npc, 32'h104);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("hyst.ctr01_taken", bus_a.pred_taken, 1'b0);
        chk("evict.pred_taken", bus_b.pred_taken, 1'b0);
        chk("evict.pred_npc", bus_b.pred_npc, 32'h104);
        tick();

        repeat (2) begin
            set_ex(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
            tick();
        end
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("hyst.ctr11_taken", bus_a.pred_taken, 1'b1);
        tick();
        set_ex(1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("hyst.ctr10_taken", bus_a.pred_taken, 1'b1);
        chk("hyst.ctr10_npc", bus_a.pred_npc, 32'h40);
        tick();

        // Aliasing: 0x200 shares the index of 0x100 with a different tag
        set_ex(1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 32'h204);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("alias.old_taken", bus_a.pred_taken, 1'b0);
        chk("alias.old_npc", bus_a.pred_npc, 32'h104);
        tick();
        pc_if = 32'h200;
        @(negedge clk);
        chk("alias.new_taken", bus_a.pred_taken, 1'b1);
        chk("alias.new_npc", bus_a.pred_npc, 32'h80);
        tick();

        // Reset wins over a simultaneous update
        rst = 1'b1;
        set_ex(1'b1, 32'h300, 1'b1, 32'h10, 1'b0, 32'h304);
        tick();
        rst = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        pc_if = 32'h300;
        @(negedge clk);
        chk("rst_wins.pred_taken", bus_a.pred_taken, 1'b0);
        chk("rst_wins.branch_count", 64'(bus_a.branch_count), 0);
        tick();

        // Statistics saturation: 20 branches into a 4-bit counter
        for (int n = 0; n < 20; n++) begin
            set_ex(1'b1, rand_pc(), 1'($urandom_range(0, 1)), rand_pc(), 1'b0, rand_pc());
            tick();
        end
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("sat.branch_count_4b", 64'(bus_b.branch_count), 15);
        chk("sat.branch_count_32b", 64'(bus_a.branch_count), 20);
        tick();

        // Randomised traffic, checked every cycle by the compare process
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] p, t;
            rst = ($urandom_range(0, 199) == 0);
            p = rand_pc();
            t = rand_pc();
            pc_if = ($urandom_range(0, 3) == 0) ? p : rand_pc();
            if ($urandom_range(0, 3) != 0)
                set_ex(1'b1, p, 1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) == 1) ? t : rand_pc());
            else
                set_ex(1'b0, p, 1'b0, t, 1'b0, 32'h0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
